core_csr_counter_ctrl: RTL and testbench
========================================

// Module: core_csr_counter_ctrl
// PURPOSE
//  Owns and sequences the machine performance counters (mcycle, minstret) behind the CSR unit.
//  Holds two 64-bit counters and applies mcountinhibit gating.
//  Muxes 32-bit CSR reads/writes onto the lo/hi halves of each counter.
//  Arbitrates CSR-write vs. hardware-increment on the same cycle.
//  Sits between the CSR decode/access stage and the retire signal from the core pipeline.
// PARAMETERS
//  CSR_XLEN     32  CSR data width; counter halves are CSR_XLEN each
//  CNT_W        64  counter width; fixed at 2*CSR_XLEN
//  HAS_INSTRET  1   0: minstret/instret* read as 0, writes are ignored (no error)
// PORTS
//  clk            in   1         core clock
//  rst_n          in   1         asynchronous, active-low reset
//  instr_ret_i    in   1         one instruction retired this cycle
//  csr_req_i      in   1         CSR access request; accepted when csr_req_i & csr_ready_o
//  csr_we_i       in   1         1=write, 0=read (qualified by req)
//  csr_addr_i     in   12        CSR address
//  csr_wdata_i    in   CSR_XLEN  write data
//  csr_ready_o    out  1         controller can accept a request this cycle
//  csr_ack_o      out  1         1-cycle pulse, response valid
//  csr_rdata_o    out  CSR_XLEN  read data (old value of the addressed CSR)
//  csr_err_o      out  1         with ack: illegal address or write to read-only alias
//  mcountinhibit_o out 3         current inhibit register {IR,0,CY}
// BEHAVIOUR
//  Reset (async): both counters=0, mcountinhibit=0, FSM=IDLE, ready=1, ack=0, rdata=0, err=0.
//  Address map: B00 mcycle, B80 mcycleh, B02 minstret, B82 minstreth, 320 mcountinhibit (RW).
//   C00 cycle, C80 cycleh, C02 instret, C82 instreth are read-only aliases of the same counters.
//  FSM: IDLE --accept--> RESP --(always)--> IDLE; ready=1 only in IDLE. A req in RESP is not accepted.
//   The requester holds req until ready.
//  Latency: ack asserts exactly 1 cycle after the accept edge, for 1 cycle.
//   rdata/err are registered at the accept edge and cleared to 0 on the non-ack cycle.
//  Read data = value before the accept edge. A write returns the old value (CSRRW semantics).
//  Write effect is visible from the accept edge onward.
//  Increment: mcycle += 1 each cycle when !inhibit[0].
//   minstret += 1 when instr_ret_i & !inhibit[2].
//   Carry lo->hi at lo=FFFF_FFFF. Full wrap: FFFF..FF -> 0, no flag.
//  Write vs. increment in the same cycle: write wins.
//   Write lo: lo<=wdata, hi unchanged; that cycle's increment and carry are dropped.
//   Write hi: hi<=wdata; lo still increments; any carry into hi that cycle is dropped.
//  mcountinhibit write: bits 0 and 2 stored; all other bits read 0.
//   The new value gates increments from the cycle after the accept edge.
//  Error (err=1 with ack, no state change): unknown address, or a write to a C-range alias.
//   rdata=0 on an error.
//  Reset mid-operation: an async assert clears everything immediately; a pending ack is lost.
// STRUCTURE
//  Shared defines.vh: CSR_XLEN, CNT_W, CSR address constants (CSR_MCYCLE..CSR_MCOUNTINHIBIT),
//   and the inhibit bit indices INH_CY=0, INH_IR=2.
//  Sub-module core_csr_cnt64: 64-bit counter with inc_i, ld_lo_i, ld_hi_i, ld_data_i.
//   Implements the write-wins and carry-drop rules; instantiated twice (cycle, instret).
//  Top: address decode, FSM, read mux, response registers.
// TESTING
//  1. Reset, then 10 idle cycles; read B00 -> ack on the next cycle, rdata=10±accept offset.
//     The bench checks the exact count against its own cycle model; err=0.
//  2. Write B00=FFFF_FFFE and B80=0, then wait 3 cycles; read B80 -> 1, read B00 -> small value.
//     Confirms the carry and the 64-bit wrap-from-lo.
//  3. Preload B00/B80 to all-ones with CY inhibited; write 320=0; after 1 cycle read B00 and B80 -> 0 and 0.
//     Confirms full wrap.
//  4. Write 320=5; pulse instr_ret_i 4 times; read B02 -> unchanged and mcycle frozen.
//     Then write 320=0 and 3 retires -> B02 increases by 3.
//  5. Write C00 -> err=1, mcycle unaffected. Read 0x7FF -> err=1, rdata=0.
//     A req while in RESP stays unaccepted until ready.
//  6. Assert rst_n low while in RESP -> ack never fires; after release, all counters=0 and ready=1.

Source files
------------

// File: rtl/core_csr_counter_ctrl_pkg.sv
// Shared types and constants for the machine performance-counter controller.
package core_csr_counter_ctrl_pkg;

   // CSR data width; each counter is two CSR-wide halves
   localparam int unsigned CSR_XLEN = 32;
   localparam int unsigned CNT_W    = 2 * CSR_XLEN;

   // Machine-mode read/write counter addresses
   localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

   // User-level read-only aliases of the same counters
   localparam logic [11:0] CSR_CYCLE         = 12'hC00;
   localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
   localparam logic [11:0] CSR_INSTRET       = 12'hC02;
   localparam logic [11:0] CSR_INSTRETH      = 12'hC82;

   // Bit positions inside mcountinhibit
   localparam int unsigned INH_CY = 0;
   localparam int unsigned INH_IR = 2;

   // Access FSM: one response cycle follows every accepted request
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } csr_state_t;

   // Decoded target of a CSR access
   typedef enum logic [2:0] {
      SEL_NONE  = 3'd0,
      SEL_CY_LO = 3'd1,
      SEL_CY_HI = 3'd2,
      SEL_IR_LO = 3'd3,
      SEL_IR_HI = 3'd4,
      SEL_INH   = 3'd5
   } csr_sel_t;

endpackage

// File: rtl/core_csr_counter_ctrl_cnt64.sv
// 64-bit performance counter built from two CSR-wide halves.
// A load of either half wins over the hardware increment in the same cycle:
//  - loading lo drops that cycle's increment and its carry;
//  - loading hi lets lo still increment, but the carry into hi is dropped.
module core_csr_cnt64
   import core_csr_counter_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                inc_i,
   input  logic                ld_lo_i,
   input  logic                ld_hi_i,
   input  logic [CSR_XLEN-1:0] ld_data_i,
   output logic [CNT_W-1:0]    cnt_o
);

   logic [CSR_XLEN-1:0] lo_q, hi_q;
   logic [CSR_XLEN-1:0] lo_d, hi_d;
   logic                carry;

   // Next-value logic: loads take priority, carry propagates only on a free increment
   always_comb begin
      lo_d  = lo_q;
      hi_d  = hi_q;
      carry = inc_i & (lo_q == '1);
      if (ld_lo_i) begin
         lo_d = ld_data_i;
      end else if (inc_i) begin
         lo_d = lo_q + CSR_XLEN'(1);
      end
      if (ld_hi_i) begin
         hi_d = ld_data_i;
      end else if (carry && !ld_lo_i) begin
         hi_d = hi_q + CSR_XLEN'(1);
      end
   end

   // Counter halves
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_q <= '0;
         hi_q <= '0;
      end else begin
         lo_q <= lo_d;
         hi_q <= hi_d;
      end
   end

   assign cnt_o = {hi_q, lo_q};

endmodule

// File: rtl/core_csr_counter_ctrl.sv
// Machine performance-counter controller (mcycle, minstret, mcountinhibit).
// Handshake: a request is accepted on a clock edge where csr_req_i & csr_ready_o;
// the requester holds csr_req_i (and its address/data) until ready is seen. ready
// is high only in IDLE. Exactly one cycle after the accept edge csr_ack_o pulses
// for one cycle with csr_rdata_o (value before the accept edge) and csr_err_o;
// both are 0 whenever ack is low.
module core_csr_counter_ctrl
   import core_csr_counter_ctrl_pkg::*;
#(
   parameter bit HAS_INSTRET = 1'b1
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                instr_ret_i,
   input  logic                csr_req_i,
   input  logic                csr_we_i,
   input  logic [11:0]         csr_addr_i,
   input  logic [CSR_XLEN-1:0] csr_wdata_i,
   output logic                csr_ready_o,
   output logic                csr_ack_o,
   output logic [CSR_XLEN-1:0] csr_rdata_o,
   output logic                csr_err_o,
   output logic [2:0]          mcountinhibit_o,
   output csr_state_t          dbg_state_o
);

   csr_state_t          state_q, state_d;
   csr_sel_t            sel;
   logic                alias_ro;
   logic                err_d;
   logic                accept;
   logic                wr_ok;
   logic [CSR_XLEN-1:0] rd_val;
   logic [2:0]          inh_q;
   logic [CNT_W-1:0]    cy_cnt, ir_cnt;
   logic                ack_q, err_q;
   logic [CSR_XLEN-1:0] rdata_q;

   // Address decode: which register is targeted and whether it is a read-only alias
   always_comb begin
      sel      = SEL_NONE;
      alias_ro = 1'b0;
      case (csr_addr_i)
         CSR_MCYCLE:        sel = SEL_CY_LO;
         CSR_MCYCLEH:       sel = SEL_CY_HI;
         CSR_MINSTRET:      sel = SEL_IR_LO;
         CSR_MINSTRETH:     sel = SEL_IR_HI;
         CSR_MCOUNTINHIBIT: sel = SEL_INH;
         CSR_CYCLE:    begin sel = SEL_CY_LO; alias_ro = 1'b1; end
         CSR_CYCLEH:   begin sel = SEL_CY_HI; alias_ro = 1'b1; end
         CSR_INSTRET:  begin sel = SEL_IR_LO; alias_ro = 1'b1; end
         CSR_INSTRETH: begin sel = SEL_IR_HI; alias_ro = 1'b1; end
         default: ;
      endcase
   end

   assign err_d  = (sel == SEL_NONE) | (csr_we_i & alias_ro);
   assign accept = csr_req_i & csr_ready_o;
   assign wr_ok  = accept & csr_we_i & ~err_d;

   // Read mux; instret reads as zero when the instret counter is not built
   always_comb begin
      rd_val = '0;
      case (sel)
         SEL_CY_LO: rd_val = cy_cnt[CSR_XLEN-1:0];
         SEL_CY_HI: rd_val = cy_cnt[CNT_W-1:CSR_XLEN];
         SEL_IR_LO: rd_val = HAS_INSTRET ? ir_cnt[CSR_XLEN-1:0] : '0;
         SEL_IR_HI: rd_val = HAS_INSTRET ? ir_cnt[CNT_W-1:CSR_XLEN] : '0;
         SEL_INH:   rd_val = {{(CSR_XLEN-3){1'b0}}, inh_q};
         default:   rd_val = '0;
      endcase
   end

   // FSM next state and ready
   always_comb begin
      state_d     = state_q;
      csr_ready_o = (state_q == ST_IDLE);
      case (state_q)
         ST_IDLE: if (csr_req_i) state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Response registers: captured at the accept edge, zero on every other cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ack_q   <= accept;
         err_q   <= accept & err_d;
         rdata_q <= (accept && !err_d) ? rd_val : '0;
      end
   end

   // mcountinhibit: only CY and IR are implemented, bit 1 is hardwired to zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inh_q <= '0;
      end else if (wr_ok && sel == SEL_INH) begin
         inh_q <= {csr_wdata_i[INH_IR], 1'b0, csr_wdata_i[INH_CY]};
      end
   end

   core_csr_cnt64 u_cycle (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc_i     (~inh_q[INH_CY]),
      .ld_lo_i   (wr_ok & (sel == SEL_CY_LO)),
      .ld_hi_i   (wr_ok & (sel == SEL_CY_HI)),
      .ld_data_i (csr_wdata_i),
      .cnt_o     (cy_cnt)
   );

   core_csr_cnt64 u_instret (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc_i     (HAS_INSTRET & instr_ret_i & ~inh_q[INH_IR]),
      .ld_lo_i   (HAS_INSTRET & wr_ok & (sel == SEL_IR_LO)),
      .ld_hi_i   (HAS_INSTRET & wr_ok & (sel == SEL_IR_HI)),
      .ld_data_i (csr_wdata_i),
      .cnt_o     (ir_cnt)
   );

   assign csr_ack_o       = ack_q;
   assign csr_err_o       = err_q;
   assign csr_rdata_o     = rdata_q;
   assign mcountinhibit_o = inh_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_core_csr_counter_ctrl.sv
// Directed testbench for the machine performance-counter controller.
module tb_core_csr_counter_ctrl;
   import core_csr_counter_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_ret_i;
   logic        csr_req_i;
   logic        csr_we_i;
   logic [11:0] csr_addr_i;
   logic [31:0] csr_wdata_i;
   logic        csr_ready_o;
   logic        csr_ack_o;
   logic [31:0] csr_rdata_o;
   logic        csr_err_o;
   logic [2:0]  mcountinhibit_o;
   csr_state_t  dbg_state_o;

   int tests_run    = 0;
   int tests_failed = 0;
   int edge_cnt;

   core_csr_counter_ctrl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .instr_ret_i     (instr_ret_i),
      .csr_req_i       (csr_req_i),
      .csr_we_i        (csr_we_i),
      .csr_addr_i      (csr_addr_i),
      .csr_wdata_i     (csr_wdata_i),
      .csr_ready_o     (csr_ready_o),
      .csr_ack_o       (csr_ack_o),
      .csr_rdata_o     (csr_rdata_o),
      .csr_err_o       (csr_err_o),
      .mcountinhibit_o (mcountinhibit_o),
      .dbg_state_o     (dbg_state_o)
   );

   // Clock
   always #5 clk = ~clk;

   // Cycle model: number of rising edges since reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Driver: one CSR access; starts and ends on a falling edge.
   // acc_edge returns the cycle-model index of the accept edge.
   task automatic csr_xfer(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int acc_edge);
      int waited = 0;
      csr_req_i   = 1'b1;
      csr_we_i    = we;
      csr_addr_i  = addr;
      csr_wdata_i = wdata;
      while (!csr_ready_o && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!csr_ready_o) begin
         tests_run++; tests_failed++;
         $display("FAIL xfer_ready_timeout: addr %h ready=%b required 1", addr, csr_ready_o);
         csr_req_i = 1'b0;
         rdata = '0; err = 1'b1; acc_edge = -1;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      acc_edge  = edge_cnt;
      csr_req_i = 1'b0;
      csr_we_i  = 1'b0;
      rdata     = csr_rdata_o;
      err       = csr_err_o;
      tests_run++;
      if (csr_ack_o !== 1'b1) begin tests_failed++; $display("FAIL xfer_ack: addr %h ack=%b required 1", addr, csr_ack_o); end
   endtask

   // Driver: n single-cycle retire pulses
   task automatic retire(input int n);
      for (int i = 0; i < n; i++) begin
         instr_ret_i = 1'b1;
         @(negedge clk);
         instr_ret_i = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      logic [31:0] rd; logic er; int e;
      rst_n = 1'b0; instr_ret_i = 1'b0; csr_req_i = 1'b0; csr_we_i = 1'b0;
      csr_addr_i = '0; csr_wdata_i = '0;
      repeat (3) @(negedge clk);
      tests_run++; if (csr_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b required 1", csr_ready_o); end
      tests_run++; if (csr_ack_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ack: got %b required 0", csr_ack_o); end
      tests_run++; if (csr_rdata_o !== 32'd0) begin tests_failed++; $display("FAIL reset_rdata: got %h required 0", csr_rdata_o); end
      tests_run++; if (csr_err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b required 0", csr_err_o); end
      tests_run++; if (mcountinhibit_o !== 3'b000) begin tests_failed++; $display("FAIL reset_inhibit: got %b required 000", mcountinhibit_o); end
      tests_run++; if (dbg_state_o !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d required IDLE", dbg_state_o); end
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      // 10 idle edges, accept on edge 11, read returns the count before it
      csr_xfer(1'b0, CSR_MCYCLE, 32'd0, rd, er, e);
      tests_run++; if (rd !== 32'd10) begin tests_failed++; $display("FAIL idle_mcycle: got %0d required 10", rd); end
      tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL idle_mcycle_err: got %b required 0", er); end
      tests_run++; if (csr_ack_o !== 1'b1 || dbg_state_o !== ST_RESP) begin tests_failed++; $display("FAIL idle_resp_state: ack %b state %0d required 1/RESP", csr_ack_o, dbg_state_o); end
   endtask

   task automatic test_carry();
      logic [31:0] rd; logic er; int e1, e2, e3, e4;
      logic [63:0] exp64;
      csr_xfer(1'b1, CSR_MCYCLEH, 32'd0, rd, er, e1);
      csr_xfer(1'b1, CSR_MCYCLE, 32'hFFFF_FFFE, rd, er, e2);
      // write returns the old low half: all edges since reset incremented
      tests_run++; if (rd !== 32'(e2 - 1)) begin tests_failed++; $display("FAIL carry_old_value: got %h required %h", rd, 32'(e2 - 1)); end
      repeat (3) @(negedge clk);
      csr_xfer(1'b0, CSR_MCYCLEH, 32'd0, rd, er, e3);
      tests_run++; if (rd !== 32'd1) begin tests_failed++; $display("FAIL carry_hi: got %h required 1", rd); end
      csr_xfer(1'b0, CSR_MCYCLE, 32'd0, rd, er, e4);
      exp64 = 64'h0000_0000_FFFF_FFFE + 64'(e4 - 1 - e2);
      tests_run++; if (rd !== exp64[31:0]) begin tests_failed++; $display("FAIL carry_lo: got %h required %h", rd, exp64[31:0]); end
   endtask

   task automatic test_full_wrap();
      logic [31:0] rd; logic er; int e, ei;
      logic [63:0] exp64;
      csr_xfer(1'b1, CSR_MCOUNTINHIBIT, 32'h1, rd, er, e);
      tests_run++; if (mcountinhibit_o !== 3'b001) begin tests_failed++; $display("FAIL wrap_inhibit_cy: got %b required 001", mcountinhibit_o); end
      csr_xfer(1'b1, CSR_MCYCLE, 32'hFFFF_FFFF, rd, er, e);
      csr_xfer(1'b1, CSR_MCYCLEH, 32'hFFFF_FFFF, rd, er, e);
      repeat (2) @(negedge clk);
      csr_xfer(1'b1, CSR_MCOUNTINHIBIT, 32'h0, rd, er, ei);
      tests_run++; if (rd !== 32'h1) begin tests_failed++; $display("FAIL wrap_inh_old: got %h required 1", rd); end
      csr_xfer(1'b0, CSR_MCYCLE, 32'd0, rd, er, e);
      exp64 = 64'hFFFF_FFFF_FFFF_FFFF + 64'(e - 1 - ei);
      tests_run++; if (rd !== 32'd0 || rd !== exp64[31:0]) begin tests_failed++; $display("FAIL wrap_lo: got %h required %h", rd, exp64[31:0]); end
      csr_xfer(1'b0, CSR_MCYCLEH, 32'd0, rd, er, e);
      exp64 = 64'hFFFF_FFFF_FFFF_FFFF + 64'(e - 1 - ei);
      tests_run++; if (rd !== exp64[63:32]) begin tests_failed++; $display("FAIL wrap_hi: got %h required %h", rd, exp64[63:32]); end
   endtask

   task automatic test_inhibit();
      logic [31:0] rd; logic er; int e, eb, ea;
      csr_xfer(1'b1, CSR_MCYCLE, 32'h1234, rd, er, eb);
      csr_xfer(1'b1, CSR_MINSTRET, 32'd7, rd, er, e);
      csr_xfer(1'b1, CSR_MCOUNTINHIBIT, 32'hFFFF_FFFF, rd, er, ea);
      tests_run++; if (mcountinhibit_o !== 3'b101) begin tests_failed++; $display("FAIL inh_out: got %b required 101", mcountinhibit_o); end
      retire(4);
      csr_xfer(1'b0, CSR_MINSTRET, 32'd0, rd, er, e);
      tests_run++; if (rd !== 32'd7) begin tests_failed++; $display("FAIL inh_minstret_frozen: got %0d required 7", rd); end
      csr_xfer(1'b0, CSR_MCYCLE, 32'd0, rd, er, e);
      // the inhibit write edge itself still counts under the old value
      tests_run++; if (rd !== 32'h1234 + 32'(ea - eb)) begin tests_failed++; $display("FAIL inh_mcycle_frozen: got %h required %h", rd, 32'h1234 + 32'(ea - eb)); end
      csr_xfer(1'b0, CSR_MCOUNTINHIBIT, 32'd0, rd, er, e);
      tests_run++; if (rd !== 32'd5) begin tests_failed++; $display("FAIL inh_readback: got %h required 5", rd); end
      csr_xfer(1'b1, CSR_MCOUNTINHIBIT, 32'd0, rd, er, e);
      retire(3);
      csr_xfer(1'b0, CSR_MINSTRET, 32'd0, rd, er, e);
      tests_run++; if (rd !== 32'd10) begin tests_failed++; $display("FAIL inh_minstret_count: got %0d required 10", rd); end
      csr_xfer(1'b0, CSR_MINSTRETH, 32'd0, rd, er, e);
      tests_run++; if (rd !== 32'd0) begin tests_failed++; $display("FAIL inh_minstreth: got %h required 0", rd); end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er; int e, ew;
      csr_xfer(1'b1, CSR_MCYCLE, 32'h100, rd, er, ew);
      csr_xfer(1'b1, CSR_CYCLE, 32'hDEAD_BEEF, rd, er, e);
      tests_run++; if (er !== 1'b1 || rd !== 32'd0) begin tests_failed++; $display("FAIL err_alias_write: err %b rdata %h required 1/0", er, rd); end
      csr_xfer(1'b0, 12'h7FF, 32'd0, rd, er, e);
      tests_run++; if (er !== 1'b1 || rd !== 32'd0) begin tests_failed++; $display("FAIL err_unknown_read: err %b rdata %h required 1/0", er, rd); end
      csr_xfer(1'b1, CSR_INSTRETH, 32'h55, rd, er, e);
      tests_run++; if (er !== 1'b1) begin tests_failed++; $display("FAIL err_instreth_write: err %b required 1", er); end
      csr_xfer(1'b0, CSR_CYCLE, 32'd0, rd, er, e);
      tests_run++; if (er !== 1'b0 || rd !== 32'h100 + 32'(e - 1 - ew)) begin tests_failed++; $display("FAIL err_cycle_unaffected: err %b rdata %h required 0/%h", er, rd, 32'h100 + 32'(e - 1 - ew)); end
      csr_xfer(1'b0, CSR_INSTRETH, 32'd0, rd, er, e);
      tests_run++; if (er !== 1'b0 || rd !== 32'd0) begin tests_failed++; $display("FAIL err_instreth_unaffected: err %b rdata %h required 0/0", er, rd); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      csr_req_i = 1'b1; csr_we_i = 1'b0; csr_addr_i = CSR_MINSTRET;
      tests_run++; if (csr_ready_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_idle: got %b required 1", csr_ready_o); end
      @(posedge clk); @(negedge clk);
      tests_run++; if (csr_ack_o !== 1'b1 || csr_rdata_o !== 32'd10) begin tests_failed++; $display("FAIL b2b_first: ack %b rdata %h required 1/a", csr_ack_o, csr_rdata_o); end
      tests_run++; if (csr_ready_o !== 1'b0 || dbg_state_o !== ST_RESP) begin tests_failed++; $display("FAIL b2b_resp_busy: ready %b state %0d required 0/RESP", csr_ready_o, dbg_state_o); end
      csr_addr_i = CSR_INSTRET;
      @(posedge clk); @(negedge clk);
      tests_run++; if (csr_ack_o !== 1'b0 || csr_ready_o !== 1'b1 || csr_rdata_o !== 32'd0) begin tests_failed++; $display("FAIL b2b_not_taken: ack %b ready %b rdata %h required 0/1/0", csr_ack_o, csr_ready_o, csr_rdata_o); end
      @(posedge clk); @(negedge clk);
      tests_run++; if (csr_ack_o !== 1'b1 || csr_rdata_o !== 32'd10 || csr_err_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_second: ack %b rdata %h err %b required 1/a/0", csr_ack_o, csr_rdata_o, csr_err_o); end
      csr_req_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er; int e;
      @(negedge clk);
      csr_req_i = 1'b1; csr_we_i = 1'b0; csr_addr_i = CSR_MCYCLE;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      csr_req_i = 1'b0;
      #1;
      tests_run++; if (csr_ack_o !== 1'b0 || csr_ready_o !== 1'b1 || csr_rdata_o !== 32'd0) begin tests_failed++; $display("FAIL rstmid_async: ack %b ready %b rdata %h required 0/1/0", csr_ack_o, csr_ready_o, csr_rdata_o); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++; if (csr_ack_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_ack_lost: cycle %0d ack %b required 0", i, csr_ack_o); end
      end
      rst_n = 1'b1;
      csr_xfer(1'b0, CSR_MCYCLE, 32'd0, rd, er, e);
      tests_run++; if (rd !== 32'd0) begin tests_failed++; $display("FAIL rstmid_mcycle: got %h required 0", rd); end
      csr_xfer(1'b0, CSR_MINSTRET, 32'd0, rd, er, e);
      tests_run++; if (rd !== 32'd0) begin tests_failed++; $display("FAIL rstmid_minstret: got %h required 0", rd); end
      csr_xfer(1'b0, CSR_MCOUNTINHIBIT, 32'd0, rd, er, e);
      tests_run++; if (rd !== 32'd0 || mcountinhibit_o !== 3'b000) begin tests_failed++; $display("FAIL rstmid_inhibit: rdata %h out %b required 0/000", rd, mcountinhibit_o); end
   endtask

   initial begin
      test_reset();
      test_carry();
      test_full_wrap();
      test_inhibit();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
